// File: rtl/cpu4_pkg.sv
// cpu4_pkg: shared opcodes, operand-mux selects, load strobe indices and FSM state encoding
package cpu4_pkg;
  localparam logic [3:0] OP_ADD_A   = 4'h0;
  localparam logic [3:0] OP_MOV_A_B = 4'h1;
  localparam logic [3:0] OP_IN_A    = 4'h2;
  localparam logic [3:0] OP_MOV_A   = 4'h3;
  localparam logic [3:0] OP_MOV_B_A = 4'h4;
  localparam logic [3:0] OP_ADD_B   = 4'h5;
  localparam logic [3:0] OP_IN_B    = 4'h6;
  localparam logic [3:0] OP_MOV_B   = 4'h7;
  localparam logic [3:0] OP_OUT_B   = 4'h9;
  localparam logic [3:0] OP_OUT_IM  = 4'hB;
  localparam logic [3:0] OP_JNC     = 4'hE;
  localparam logic [3:0] OP_JMP     = 4'hF;
  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_SW   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_e;
endpackage

// File: rtl/cpu4_sequencer_if.sv
// cpu4_sequencer_if: program ROM fetch handshake
//   rom_req  : fetch request (master -> slave)
//   rom_addr : fetch address, PC_W bits (master -> slave)
//   rom_ack  : rom_data valid this cycle (slave -> master)
//   rom_data : 8-bit instruction (slave -> master)
interface cpu4_sequencer_if #(parameter int PC_W = 4);
  logic            rom_req;
  logic [PC_W-1:0] rom_addr;
  logic            rom_ack;
  logic [7:0]      rom_data;
  modport master (output rom_req, rom_addr, input rom_ack, rom_data);
  modport slave (input rom_req, rom_addr, output rom_ack, rom_data);
endinterface

// File: rtl/cpu4_decode.sv
// cpu4_decode: opcode to operand select, immediate use, load strobes and jump flags
//   op_i      : instruction opcode
//   sel_o     : operand mux select
//   use_imm_o : immediate drives the adder second operand
//   load_o    : one-hot register write strobe (bit 3 always 0)
//   is_jmp_o  : unconditional jump
//   is_jnc_o  : jump if carry clear
module cpu4_decode
  import cpu4_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [1:0] sel_o,
  output logic       use_imm_o,
  output logic [3:0] load_o,
  output logic       is_jmp_o,
  output logic       is_jnc_o
);
  always_comb begin
    sel_o = SEL_A;
    use_imm_o = 1'b0;
    load_o = 4'b0000;
    case (op_i)
      OP_ADD_A:   begin sel_o = SEL_A;    use_imm_o = 1'b1; load_o[LD_A]   = 1'b1; end
      OP_ADD_B:   begin sel_o = SEL_B;    use_imm_o = 1'b1; load_o[LD_B]   = 1'b1; end
      OP_MOV_A:   begin sel_o = SEL_ZERO; use_imm_o = 1'b1; load_o[LD_A]   = 1'b1; end
      OP_MOV_B:   begin sel_o = SEL_ZERO; use_imm_o = 1'b1; load_o[LD_B]   = 1'b1; end
      OP_MOV_A_B: begin sel_o = SEL_B;                      load_o[LD_A]   = 1'b1; end
      OP_MOV_B_A: begin sel_o = SEL_A;                      load_o[LD_B]   = 1'b1; end
      OP_IN_A:    begin sel_o = SEL_SW;                     load_o[LD_A]   = 1'b1; end
      OP_IN_B:    begin sel_o = SEL_SW;                     load_o[LD_B]   = 1'b1; end
      OP_OUT_B:   begin sel_o = SEL_B;                      load_o[LD_OUT] = 1'b1; end
      OP_OUT_IM:  begin sel_o = SEL_ZERO; use_imm_o = 1'b1; load_o[LD_OUT] = 1'b1; end
      default: ;
    endcase
  end
  assign is_jmp_o = op_i == OP_JMP;
  assign is_jnc_o = op_i == OP_JNC;
endmodule

// File: rtl/cpu4_sequencer.sv
// cpu4_sequencer: fetch/execute control for the 4-bit register/adder datapath
//   ck, res : clock, asynchronous active-low reset
//   run     : allow new fetches (sampled in IDLE and at the end of EXEC)
//   rom     : program ROM fetch handshake (master side)
//   cy_in   : datapath adder carry-out, valid during EXEC
//   sel/imm/load : datapath controls, nonzero only during EXEC
//   pc, carry    : program counter and carry flag
module cpu4_sequencer
  import cpu4_pkg::*;
#(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    ck,
  input  logic                    res,
  input  logic                    run,
  cpu4_sequencer_if.master        rom,
  input  logic                    cy_in,
  output logic [1:0]              sel,
  output logic [3:0]              imm,
  output logic [3:0]              load,
  output logic [PC_W-1:0]         pc,
  output logic                    carry
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            carry_q, carry_d;
  logic [1:0]      dec_sel;
  logic [3:0]      dec_load;
  logic            dec_use_imm, dec_jmp, dec_jnc, exec;
  cpu4_decode u_decode (
    .op_i      (ir_q[7:4]),
    .sel_o     (dec_sel),
    .use_imm_o (dec_use_imm),
    .load_o    (dec_load),
    .is_jmp_o  (dec_jmp),
    .is_jnc_o  (dec_jnc)
  );
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      ir_q <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      carry_q <= carry_d;
    end
  end
  // JNC tests the carry held before this EXEC, so carry_q is used, not carry_d.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (rom.rom_ack) begin
          ir_d = rom.rom_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
        carry_d = |dec_load ? cy_in : carry_q;
        pc_d = (dec_jmp || (dec_jnc && !carry_q)) ? PC_W'(ir_q[3:0]) : pc_q + PC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    exec = state_q == S_EXEC;
    rom.rom_req = state_q == S_FETCH;
    sel = exec ? dec_sel : SEL_A;
    imm = (exec && dec_use_imm) ? ir_q[3:0] : 4'd0;
    load = exec ? dec_load : 4'd0;
  end
  assign rom.rom_addr = pc_q;
  assign pc = pc_q;
  assign carry = carry_q;
endmodule

// File: tb/tb_cpu4_sequencer.sv
// tb_cpu4_sequencer: directed self-checking bench with a small ROM responder
module tb_cpu4_sequencer;
  logic ck = 1'b0;
  logic res = 1'b0;
  logic run = 1'b0;
  logic cy_in = 1'b0;
  logic [1:0] sel;
  logic [3:0] imm, load, pc;
  logic carry;
  logic [7:0] rom [16];
  int wcnt = 0;
  int ack_delay = 0;
  int n_run = 0;
  int n_fail = 0;
  logic [15:0] snap;
  cpu4_sequencer_if #(.PC_W(4)) bus ();
  cpu4_sequencer #(.PC_W(4), .RESET_PC(4'd0)) dut (
    .ck    (ck),
    .res   (res),
    .run   (run),
    .rom   (bus),
    .cy_in (cy_in),
    .sel   (sel),
    .imm   (imm),
    .load  (load),
    .pc    (pc),
    .carry (carry)
  );
  always #5 ck = ~ck;
  assign bus.rom_ack = bus.rom_req && (wcnt == ack_delay);
  assign bus.rom_data = rom[bus.rom_addr];
  always @(posedge ck) wcnt <= (bus.rom_req && !bus.rom_ack) ? wcnt + 1 : 0;
  assign snap = {bus.rom_req, sel, imm, load, pc, carry};

  task automatic test_reset;
    repeat (2) @(negedge ck);
    n_run++;
    if (snap !== 16'h0000) begin n_fail++; $display("FAIL reset_hold: got %h want %h", snap, 16'h0000); end
    res = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      n_run++;
      if (snap !== 16'h0000) begin n_fail++; $display("FAIL idle[%0d]: got %h want %h", i, snap, 16'h0000); end
    end
  endtask

  task automatic test_straight;
    logic [15:0] e [5];
    e = '{{1'b1, 2'd0, 4'h0, 4'b0000, 4'h0, 1'b0},
          {1'b0, 2'd3, 4'h5, 4'b0001, 4'h0, 1'b0},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'h1, 1'b0},
          {1'b0, 2'd0, 4'h3, 4'b0001, 4'h1, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'h2, 1'b0}};
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      n_run++;
      if (snap !== e[i]) begin n_fail++; $display("FAIL straight[%0d]: got %h want %h", i, snap, e[i]); end
      if (i == 3) run = 1'b0;
    end
  endtask

  task automatic test_wait;
    logic [15:0] e [6];
    e = '{{1'b1, 2'd0, 4'h0, 4'b0000, 4'h2, 1'b0},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'h2, 1'b0},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'h2, 1'b0},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'h2, 1'b0},
          {1'b0, 2'd3, 4'hA, 4'b0010, 4'h2, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'h3, 1'b0}};
    ack_delay = 3;
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ck);
      n_run++;
      if (snap !== e[i]) begin n_fail++; $display("FAIL wait[%0d]: got %h want %h", i, snap, e[i]); end
      if (i < 4) begin
        n_run++;
        if (bus.rom_addr !== 4'h2) begin n_fail++; $display("FAIL wait_addr[%0d]: got %h want 2", i, bus.rom_addr); end
      end
      if (i == 3) run = 1'b0;
    end
    ack_delay = 0;
  endtask

  task automatic test_jnc;
    logic [15:0] e [9];
    e = '{{1'b1, 2'd0, 4'h0, 4'b0000, 4'h3, 1'b0},
          {1'b0, 2'd0, 4'hF, 4'b0001, 4'h3, 1'b0},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'h4, 1'b1},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'h4, 1'b1},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'h5, 1'b1},
          {1'b0, 2'd3, 4'h1, 4'b0001, 4'h5, 1'b1},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'h6, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'h6, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'h8, 1'b0}};
    cy_in = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge ck);
      n_run++;
      if (snap !== e[i]) begin n_fail++; $display("FAIL jnc[%0d]: got %h want %h", i, snap, e[i]); end
      if (i == 2) cy_in = 1'b0;
      if (i == 7) run = 1'b0;
    end
  endtask

  task automatic test_jmp_wrap;
    logic [15:0] e [7];
    e = '{{1'b1, 2'd0, 4'h0, 4'b0000, 4'h8, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'h8, 1'b0},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'hF, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'hF, 1'b0},
          {1'b1, 2'd0, 4'h0, 4'b0000, 4'h0, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'h0, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'hA, 1'b0}};
    rom[0] = 8'hFA;
    cy_in = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge ck);
      n_run++;
      if (snap !== e[i]) begin n_fail++; $display("FAIL jmp_wrap[%0d]: got %h want %h", i, snap, e[i]); end
      if (i == 5) run = 1'b0;
    end
    rom[0] = 8'h35;
    cy_in = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [15:0] e [3];
    rom[10] = 8'hF6;
    run = 1'b1;
    repeat (3) @(negedge ck);
    n_run++;
    if (snap !== {1'b1, 2'd0, 4'h0, 4'b0000, 4'h6, 1'b0} || bus.rom_addr !== 4'h6) begin
      n_fail++; $display("FAIL pre_reset_fetch: got %h addr %h want req=1 pc=6 addr=6", snap, bus.rom_addr);
    end
    #2 res = 1'b0;
    #1;
    n_run++;
    if (snap !== 16'h0000) begin n_fail++; $display("FAIL async_reset: got %h want %h", snap, 16'h0000); end
    @(negedge ck);
    n_run++;
    if (snap !== 16'h0000) begin n_fail++; $display("FAIL reset_held: got %h want %h", snap, 16'h0000); end
    res = 1'b1;
    e = '{{1'b1, 2'd0, 4'h0, 4'b0000, 4'h0, 1'b0},
          {1'b0, 2'd3, 4'h5, 4'b0001, 4'h0, 1'b0},
          {1'b0, 2'd0, 4'h0, 4'b0000, 4'h1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      n_run++;
      if (snap !== e[i]) begin n_fail++; $display("FAIL restart[%0d]: got %h want %h", i, snap, e[i]); end
      if (i == 1) run = 1'b0;
    end
  endtask

  task automatic test_decode;
    logic [7:0] prog [8];
    logic [9:0] e [8];
    prog = '{8'h20, 8'h90, 8'hB7, 8'h40, 8'h6F, 8'h1F, 8'h5C, 8'hC3};
    e = '{{2'd2, 4'h0, 4'b0001}, {2'd1, 4'h0, 4'b0100}, {2'd3, 4'h7, 4'b0100}, {2'd0, 4'h0, 4'b0010},
          {2'd2, 4'h0, 4'b0010}, {2'd1, 4'h0, 4'b0001}, {2'd1, 4'hC, 4'b0010}, {2'd0, 4'h0, 4'b0000}};
    for (int i = 0; i < 8; i++) rom[i+1] = prog[i];
    cy_in = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ck);
      n_run++;
      if ({bus.rom_req, bus.rom_addr} !== {1'b1, 4'(i + 1)}) begin
        n_fail++; $display("FAIL dec_fetch[%0d]: got req=%b addr=%h want req=1 addr=%h", i, bus.rom_req, bus.rom_addr, 4'(i + 1));
      end
      if (i == 7) begin cy_in = 1'b0; run = 1'b0; end
      @(negedge ck);
      n_run++;
      if ({sel, imm, load} !== e[i]) begin n_fail++; $display("FAIL dec_exec[%0d]: got %h want %h", i, {sel, imm, load}, e[i]); end
    end
    @(negedge ck);
    n_run++;
    if ({bus.rom_req, pc, carry} !== {1'b0, 4'h9, 1'b1}) begin
      n_fail++; $display("FAIL dec_end: got req=%b pc=%h carry=%b want req=0 pc=9 carry=1", bus.rom_req, pc, carry);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h35; rom[1] = 8'h03; rom[2] = 8'h7A; rom[3] = 8'h0F;
    rom[4] = 8'hE8; rom[5] = 8'h31; rom[6] = 8'hE8; rom[8] = 8'hFF;
    test_reset;
    test_straight;
    test_wait;
    test_jnc;
    test_jmp_wrap;
    test_async_reset;
    test_decode;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
